// File: rtl/wb_vec_cmd_bridge_pkg.sv
// Shared register map, bit positions and data word type for the Wishbone vector bridge.
package vec_bridge_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_RESULT = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_CMD_FULL  = 0;
  localparam int ST_CMD_EMPTY = 1;
  localparam int ST_RES_FULL  = 2;
  localparam int ST_RES_EMPTY = 3;
  localparam int ST_ERR_OVF   = 4;
  localparam int ST_ERR_UNF   = 5;
  localparam int ST_ERR_SEL   = 6;
  localparam int ST_CMD_CNT   = 8;
  localparam int ST_RES_CNT   = 16;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/wb_vec_cmd_bridge_if.sv
// Bus-side (Wishbone slave) and core-side (cmd/res streams) signals of the vector bridge.
interface wb_vec_cmd_bridge_if;
  import vec_bridge_pkg::*;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  word_t       wbs_dat_i;
  logic        wbs_ack_o;
  word_t       wbs_dat_o;

  // val/rdy streams: a word moves on a clock edge where val and rdy are both high;
  // a source holds val and its message steady until that edge.
  logic        cmd_val_o;
  logic        cmd_rdy_i;
  word_t       cmd_msg_o;
  logic        res_val_i;
  logic        res_rdy_o;
  word_t       res_msg_i;
  logic        irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output cmd_val_o, cmd_msg_o,
    input  cmd_rdy_i,
    input  res_val_i, res_msg_i,
    output res_rdy_o, irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  cmd_val_o, cmd_msg_o,
    output cmd_rdy_i,
    output res_val_i, res_msg_i,
    input  res_rdy_o, irq_o
  );

endinterface

// File: rtl/wb_vec_cmd_bridge_fifo.sv
// Synchronous FIFO with full/empty/count; DEPTH must be a power of two so pointers wrap naturally.
module vec_bridge_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_vec_cmd_bridge.sv
// Wishbone register window bridging the management SoC to the vector core's command/result streams.
// Optional feature macro: WB_VEC_BRIDGE_IRQ_EN enables the result-available interrupt and CTRL[1].
module wb_vec_cmd_bridge
  import vec_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CMD_DEPTH = 8,
  parameter int          RES_DEPTH = 8
) (
  input logic                clk,
  input logic                reset,
  wb_vec_cmd_bridge_if.slave bus
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);

  logic       ack_q, ack_d;
  word_t      dat_q, dat_d;
  logic       err_ovf_q, err_ovf_d, err_unf_q, err_unf_d, err_sel_q, err_sel_d;
  logic       irq_en_q, irq_en_d, irq_q, irq_d;
  logic       req, in_win, bus_wr, bus_rd, clear;
  logic [1:0] off;
  logic       cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic       res_push, res_pop, res_full, res_empty;
  logic [CAW:0] cmd_cnt;
  logic [RAW:0] res_cnt;
  word_t      cmd_head, res_head, status;
  logic       unused_adr;

  assign unused_adr = ^bus.wbs_adr_i[1:0];

  // ack_q masks the request so every access is acked exactly once, even if stb stays high.
  assign req    = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
  assign in_win = (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign off    = bus.wbs_adr_i[3:2];
  assign bus_wr = req & in_win & bus.wbs_we_i;
  assign bus_rd = req & in_win & ~bus.wbs_we_i;

  assign clear    = bus_wr & (off == REG_CTRL) & bus.wbs_dat_i[CTRL_CLEAR];
  assign cmd_push = bus_wr & (off == REG_CMD) & (bus.wbs_sel_i == 4'hF);
  assign cmd_pop  = ~cmd_empty & bus.cmd_rdy_i;
  assign res_pop  = bus_rd & (off == REG_RESULT);
  assign res_push = bus.res_val_i & bus.res_rdy_o;

  assign bus.cmd_val_o = ~cmd_empty;
  assign bus.cmd_msg_o = cmd_head;
  assign bus.res_rdy_o = ~res_full | res_pop;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.irq_o     = irq_q;

  vec_bridge_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(32)) u_cmd_fifo (
    .clk(clk), .reset(reset), .clr_i(clear), .push_i(cmd_push), .pop_i(bus.cmd_rdy_i),
    .wdata_i(bus.wbs_dat_i), .rdata_o(cmd_head), .full_o(cmd_full), .empty_o(cmd_empty),
    .count_o(cmd_cnt)
  );

  vec_bridge_fifo #(.DEPTH(RES_DEPTH), .WIDTH(32)) u_res_fifo (
    .clk(clk), .reset(reset), .clr_i(clear), .push_i(res_push), .pop_i(res_pop),
    .wdata_i(bus.res_msg_i), .rdata_o(res_head), .full_o(res_full), .empty_o(res_empty),
    .count_o(res_cnt)
  );

  always_comb begin
    status                     = '0;
    status[ST_CMD_FULL]        = cmd_full;
    status[ST_CMD_EMPTY]       = cmd_empty;
    status[ST_RES_FULL]        = res_full;
    status[ST_RES_EMPTY]       = res_empty;
    status[ST_ERR_OVF]         = err_ovf_q;
    status[ST_ERR_UNF]         = err_unf_q;
    status[ST_ERR_SEL]         = err_sel_q;
    status[ST_CMD_CNT +: 8]    = 8'(cmd_cnt);
    status[ST_RES_CNT +: 8]    = 8'(res_cnt);
  end

  always_comb begin
    ack_d     = req;
    dat_d     = '0;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    err_sel_d = err_sel_q;
    irq_en_d  = irq_en_q;
    irq_d     = 1'b0;
    if (bus_rd) begin
      case (off)
        REG_RESULT: dat_d = res_empty ? '0 : res_head;
        REG_STATUS: dat_d = status;
        REG_CTRL:   dat_d[CTRL_IRQ_EN] = irq_en_q;
        default:    dat_d = '0;
      endcase
    end
    if (res_pop & res_empty) err_unf_d = 1'b1;
    if (bus_wr & (off == REG_CMD)) begin
      if (bus.wbs_sel_i != 4'hF)        err_sel_d = 1'b1;
      else if (cmd_full & ~cmd_pop)     err_ovf_d = 1'b1;
    end
`ifdef WB_VEC_BRIDGE_IRQ_EN
    if (bus_wr & (off == REG_CTRL)) irq_en_d = bus.wbs_dat_i[CTRL_IRQ_EN];
    irq_d = irq_en_q & ~res_empty;
`else
    irq_en_d = 1'b0;
`endif
    if (clear) begin
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
      err_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      err_sel_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      err_sel_q <= err_sel_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_wb_vec_cmd_bridge.sv
// Self-checking bench for wb_vec_cmd_bridge: queue-based reference model, scoreboard monitor,
// directed scenarios then randomized bus/core traffic. Honors WB_VEC_BRIDGE_IRQ_EN if defined.
module tb_wb_vec_cmd_bridge;
  import vec_bridge_pkg::*;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          CMD_D = 8;
  localparam int          RES_D = 8;
`ifdef WB_VEC_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_vec_cmd_bridge_if bus();

  wb_vec_cmd_bridge #(.BASE_ADDR(BASE), .CMD_DEPTH(CMD_D), .RES_DEPTH(RES_D)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit bus_done = 1'b0;
  bit abort_ok = 1'b0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  word_t m_cmd[$];
  word_t m_res[$];
  logic [31:0] exp_q[$];
  bit    exp_rd_q[$];
  bit    m_ovf, m_unf, m_sel, m_irq_en, m_irq, m_ack;

  task automatic model_step();
    bit req, is_rd, wr, core_pop, bus_pop, core_push;
    int off, cmd_n, res_n;
    word_t st, rd_data;
    req   = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack;
    off   = int'(bus.wbs_adr_i[3:2]);
    is_rd = req && !bus.wbs_we_i;
    wr    = req && bus.wbs_we_i && ((bus.wbs_adr_i >> 4) == (BASE >> 4));
    cmd_n = m_cmd.size();
    res_n = m_res.size();
    m_irq = IRQ_ON && m_irq_en && (res_n > 0);
    st = (cmd_n == CMD_D ? 1 : 0) + (cmd_n == 0 ? 2 : 0) + (res_n == RES_D ? 4 : 0)
       + (res_n == 0 ? 8 : 0) + (m_ovf ? 16 : 0) + (m_unf ? 32 : 0) + (m_sel ? 64 : 0)
       + cmd_n * 256 + res_n * 65536;
    rd_data = '0;
    bus_pop = 1'b0;
    if (is_rd && ((bus.wbs_adr_i >> 4) == (BASE >> 4))) begin
      case (off)
        1: if (res_n > 0) begin rd_data = m_res[0]; bus_pop = 1'b1; end else m_unf = 1'b1;
        2: rd_data = st;
        3: rd_data = (IRQ_ON && m_irq_en) ? 32'h2 : 32'h0;
        default: rd_data = '0;
      endcase
    end
    core_pop  = bus.cmd_rdy_i && (cmd_n > 0);
    core_push = bus.res_val_i && ((res_n < RES_D) || bus_pop);
    if (core_pop) void'(m_cmd.pop_front());
    if (bus_pop)  void'(m_res.pop_front());
    if (wr && off == 0) begin
      if (bus.wbs_sel_i != 4'hF)              m_sel = 1'b1;
      else if (cmd_n < CMD_D || core_pop)     m_cmd.push_back(bus.wbs_dat_i);
      else                                    m_ovf = 1'b1;
    end
    if (core_push) m_res.push_back(bus.res_msg_i);
    if (wr && off == 3) begin
      m_irq_en = IRQ_ON && bus.wbs_dat_i[1];
      if (bus.wbs_dat_i[0]) begin
        m_cmd.delete(); m_res.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_sel = 1'b0;
      end
    end
    if (req) begin
      exp_rd_q.push_back(is_rd);
      if (is_rd) exp_q.push_back(rd_data);
    end
    m_ack = req;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cmd.delete(); m_res.delete(); exp_q.delete(); exp_rd_q.delete();
      m_ovf = 0; m_unf = 0; m_sel = 0; m_irq_en = 0; m_irq = 0; m_ack = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wb_ack", 32'(bus.wbs_ack_o), 32'(exp_rd_q.size() > 0));
      if (bus.wbs_ack_o && exp_rd_q.size() > 0) begin
        if (exp_rd_q.pop_front()) chk("wb_rdata", bus.wbs_dat_o, exp_q.pop_front());
      end
      chk("cmd_val", 32'(bus.cmd_val_o), 32'(m_cmd.size() > 0));
      if (m_cmd.size() > 0) chk("cmd_msg", bus.cmd_msg_o, m_cmd[0]);
      chk("irq", 32'(bus.irq_o), 32'(m_irq));
    end
  end

  // ---------------- driver tasks (called and returning at posedge+1) ----------------
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input word_t dat,
                         input logic [3:0] sel, output word_t rdata);
    int n = 0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    @(negedge clk);
    while (!bus.wbs_ack_o && n < 16) begin @(negedge clk); n++; end
    rdata = bus.wbs_dat_o;
    n_checks++;
    if (!bus.wbs_ack_o) begin
      n_fail++;
      $display("FAIL wb_timeout: no ack for adr %h after %0d cycles", adr, n);
    end
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input word_t dat, input logic [3:0] sel);
    word_t unused_rd;
    wb_xfer(1'b1, adr, dat, sel, unused_rd);
  endtask

  task automatic wb_read(input logic [31:0] adr, output word_t rd);
    wb_xfer(1'b0, adr, '0, 4'hF, rd);
  endtask

  task automatic core_push(input word_t w);
    int n = 0;
    bus.res_val_i = 1'b1; bus.res_msg_i = w;
    @(negedge clk);
    while (!bus.res_rdy_o && n < 200 && !(abort_ok && bus_done)) begin @(negedge clk); n++; end
    if (!(abort_ok && bus_done)) begin
      n_checks++;
      if (!bus.res_rdy_o) begin
        n_fail++;
        $display("FAIL core_push_timeout: res_rdy_o low for %0d cycles", n);
      end
    end
    @(posedge clk); #1;
    bus.res_val_i = 1'b0;
  endtask

  task automatic drain_cmd(input string name);
    int n = 0;
    bus.cmd_rdy_i = 1'b1;
    @(negedge clk);
    while (bus.cmd_val_o && n < 50) begin @(negedge clk); n++; end
    chk(name, 32'(bus.cmd_val_o), 32'h0);
    @(posedge clk); #1;
    bus.cmd_rdy_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    word_t rd;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0; bus.cmd_rdy_i = 0; bus.res_val_i = 0; bus.res_msg_i = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_cmd_val", 32'(bus.cmd_val_o), 32'h0);
    chk("rst_irq", 32'(bus.irq_o), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset status
    wb_read(BASE + 32'h8, rd);
    chk("t1_status", rd, 32'h0000_000A);

    // 2: overflow the command FIFO, then drain it in order
    for (int i = 0; i < 9; i++) wb_write(BASE, 32'h11 + 32'(i), 4'hF);
    wb_read(BASE + 32'h8, rd);
    chk("t2_status_full", rd, 32'h0000_0819);
    drain_cmd("t2_drained");

    // 3: results in order, then underflow
    core_push(32'hDEAD_BEEF);
    core_push(32'h1234_5678);
    wb_read(BASE + 32'h4, rd); chk("t3_res0", rd, 32'hDEAD_BEEF);
    wb_read(BASE + 32'h4, rd); chk("t3_res1", rd, 32'h1234_5678);
    wb_read(BASE + 32'h4, rd); chk("t3_res_empty", rd, 32'h0);
    wb_read(BASE + 32'h8, rd); chk("t3_status_unf", rd, 32'h0000_003A);
    wb_write(BASE + 32'hC, 32'h1, 4'hF);
    wb_read(BASE + 32'h8, rd); chk("t3_status_clr", rd, 32'h0000_000A);

    // 4: push into a full CMD FIFO on the same edge the core pops
    for (int i = 0; i < 8; i++) wb_write(BASE, 32'h40 + 32'(i), 4'hF);
    wb_read(BASE + 32'h8, rd); chk("t4_status_full", rd, 32'h0000_0809);
    bus.cmd_rdy_i = 1'b1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE; bus.wbs_dat_i = 32'hAA; bus.wbs_sel_i = 4'hF;
    @(posedge clk); #1;
    bus.cmd_rdy_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
    wb_read(BASE + 32'h8, rd); chk("t4_status_simul", rd, 32'h0000_0809);
    drain_cmd("t4_drained");

    // 5: bad byte select, out-of-window access, clear
    wb_write(BASE, 32'h55, 4'h3);
    wb_write(BASE + 32'h20, 32'h77, 4'hF);
    wb_read(BASE + 32'h20, rd); chk("t5_oow_read", rd, 32'h0);
    wb_read(BASE + 32'h8, rd);  chk("t5_status_sel", rd, 32'h0000_004A);
    wb_write(BASE + 32'hC, 32'h1, 4'hF);
    wb_read(BASE + 32'h8, rd);  chk("t5_status_clr", rd, 32'h0000_000A);
    wb_read(BASE + 32'hC, rd);  chk("t5_ctrl_zero", rd, 32'h0);

    // 6: interrupt follows IRQ_EN & result-available with one cycle of delay
    wb_write(BASE + 32'hC, 32'h2, 4'hF);
    wb_read(BASE + 32'hC, rd); chk("t6_ctrl", rd, IRQ_ON ? 32'h2 : 32'h0);
    core_push(32'hCAFE_F00D);
    @(negedge clk); chk("t6_irq_delay", 32'(bus.irq_o), 32'h0);
    @(posedge clk); @(negedge clk); chk("t6_irq_rise", 32'(bus.irq_o), 32'(IRQ_ON));
    @(posedge clk); #1;
    wb_read(BASE + 32'h4, rd); chk("t6_res", rd, 32'hCAFE_F00D);
    @(negedge clk); chk("t6_irq_fall", 32'(bus.irq_o), 32'h0);
    @(posedge clk); #1;
    wb_write(BASE + 32'hC, 32'h0, 4'hF);

    // 7: randomized concurrent traffic
    abort_ok = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] a;
          word_t       d;
          logic [3:0]  s;
          bit          w;
          a = BASE + 32'($urandom_range(0, 3) * 4);
          if ($urandom_range(0, 15) == 0) a = a + 32'h100;
          w = ($urandom_range(0, 1) == 1);
          d = $urandom;
          if (a == BASE + 32'hC)
            d = ($urandom_range(0, 9) == 0) ? 32'h1 : (($urandom_range(0, 1) == 1) ? 32'h2 : 32'h0);
          s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
          wb_xfer(w, a, d, s, d);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        bus_done = 1'b1;
      end
      begin
        while (!bus_done) begin
          bus.cmd_rdy_i = ($urandom_range(0, 2) == 0);
          @(posedge clk); #1;
        end
        bus.cmd_rdy_i = 1'b0;
      end
      begin
        while (!bus_done) begin
          if ($urandom_range(0, 2) == 0) core_push($urandom);
          else begin @(posedge clk); #1; end
        end
      end
    join

    repeat (4) begin @(posedge clk); #1; end
    wb_read(BASE + 32'h8, rd);
    repeat (2) begin @(posedge clk); #1; end
    chk("end_exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
